// File: rtl/pwm_cfg_spi_rx_if.sv
// pwm_cfg_spi_rx_if: SPI pad pins and PWM register-write bus for pwm_cfg_spi_rx.
interface pwm_cfg_spi_rx_if;
  logic sck_i;
  logic csb_i;
  logic mosi_i;
  logic miso_o;
  logic miso_oeb_o;
  logic cfg_valid_o;
  logic cfg_ready_i;
  logic [7:0] cfg_addr_o;
  logic [15:0] cfg_data_o;
  logic overrun_o;
  logic ovr_clr_i;
  logic busy_o;
  modport master (
    input sck_i, csb_i, mosi_i, cfg_ready_i, ovr_clr_i,
    output miso_o, miso_oeb_o, cfg_valid_o, cfg_addr_o, cfg_data_o, overrun_o, busy_o
  );
  modport slave (
    output sck_i, csb_i, mosi_i, cfg_ready_i, ovr_clr_i,
    input miso_o, miso_oeb_o, cfg_valid_o, cfg_addr_o, cfg_data_o, overrun_o, busy_o
  );
endinterface

// File: rtl/pwm_cfg_spi_rx.sv
// pwm_cfg_spi_rx: SPI mode-0 receiver turning 24-bit frames into PWM register writes.
// Define PWM_CFG_PARITY_EN for 25-bit frames ending in an even-parity bit.
module pwm_cfg_spi_rx #(
  parameter int FRAME_BITS  = 24,
  parameter int SYNC_STAGES = 2
) (
  input logic wb_clk_i,
  input logic wb_rst_i,
  pwm_cfg_spi_rx_if.master bus
);
`ifdef PWM_CFG_PARITY_EN
  localparam int FB = FRAME_BITS + 1;
`else
  localparam int FB = FRAME_BITS;
`endif
  localparam int CW = $clog2(FB + 1);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t st, nxt;
  logic [SYNC_STAGES-1:0] sck_sy, csb_sy, mosi_sy, live_sy;
  logic sck_s, csb_s, mosi_s, live, sck_d, csb_d, armed;
  logic [4:0] ev_a, ev_b;
  logic rise, fall, cfall, crise, mbit;
  logic [FB-2:0] shreg;
  logic [FB-1:0] frame;
  logic [CW-1:0] cnt;
  logic [7:0] miso_sr;
  logic [FRAME_BITS-1:0] word, buf_q;
  logic valid, ovr, shift_en, complete, par_ok, accept;
  assign sck_s  = sck_sy[SYNC_STAGES-1];
  assign csb_s  = csb_sy[SYNC_STAGES-1];
  assign mosi_s = mosi_sy[SYNC_STAGES-1];
  assign live   = live_sy[SYNC_STAGES-1];
  // armed blocks a csb fall until csb is seen high from the pin, so a frame cut by reset is not resumed
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      sck_sy  <= '0;
      csb_sy  <= '1;
      mosi_sy <= '0;
      live_sy <= '0;
      sck_d   <= 1'b0;
      csb_d   <= 1'b1;
      armed   <= 1'b0;
      ev_a    <= '0;
      ev_b    <= '0;
    end else begin
      sck_sy  <= {sck_sy[SYNC_STAGES-2:0], bus.sck_i};
      csb_sy  <= {csb_sy[SYNC_STAGES-2:0], bus.csb_i};
      mosi_sy <= {mosi_sy[SYNC_STAGES-2:0], bus.mosi_i};
      live_sy <= {live_sy[SYNC_STAGES-2:0], 1'b1};
      sck_d   <= sck_s;
      csb_d   <= csb_s;
      armed   <= armed | (live & csb_s);
      ev_a    <= {sck_s & ~sck_d, ~sck_s & sck_d, armed & ~csb_s & csb_d, csb_s & ~csb_d, mosi_s};
      ev_b    <= ev_a;
    end
  end
  always_ff @(posedge wb_clk_i) st <= wb_rst_i ? IDLE : nxt;
  always_comb begin
    {rise, fall, cfall, crise, mbit} = ev_b;
    frame    = {shreg, mbit};
    shift_en = st == SHIFT && rise && !crise;
    complete = shift_en && cnt == CW'(FB - 1);
`ifdef PWM_CFG_PARITY_EN
    par_ok = ~^frame;
    word   = frame[FB-1:1];
`else
    par_ok = 1'b1;
    word   = frame;
`endif
    accept = complete && par_ok && (!valid || bus.cfg_ready_i);
    nxt    = crise ? IDLE : (st == IDLE && cfall) ? SHIFT : complete ? DONE : st;
  end
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      shreg   <= '0;
      cnt     <= '0;
      miso_sr <= '0;
      buf_q   <= '0;
      valid   <= 1'b0;
      ovr     <= 1'b0;
    end else begin
      if (st == IDLE && cfall) begin
        cnt     <= '0;
        miso_sr <= {6'b0, ovr, valid};
      end
      if (shift_en) begin
        shreg <= frame[FB-2:0];
        cnt   <= cnt + CW'(1);
      end
      if (st == SHIFT && fall && !crise) miso_sr <= {miso_sr[6:0], 1'b0};
      if (accept) buf_q <= word;
      valid <= accept | (valid & ~bus.cfg_ready_i);
      ovr   <= (complete & ~accept) | (ovr & ~bus.ovr_clr_i);
    end
  end
  assign bus.miso_o      = miso_sr[7];
  assign bus.miso_oeb_o  = csb_s;
  assign bus.cfg_valid_o = valid;
  assign bus.cfg_addr_o  = buf_q[23:16];
  assign bus.cfg_data_o  = buf_q[15:0];
  assign bus.overrun_o   = ovr;
  assign bus.busy_o      = st != IDLE;
endmodule
